// File: rtl/regfile_sb.sv
// Parametrised multi-port register file with write-through bypass and a per-register
// pending (scoreboard) bit used to track outstanding loads.
module regfile_sb #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned NREGS   = 8,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter int unsigned NRP     = 2,
    parameter bit          ZERO_R0 = 1'b0,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic                   ph1,
    input  logic                   reset,
    input  logic                   we_a,
    input  logic [AW-1:0]          wa_a,
    input  logic [WIDTH-1:0]       wd_a,
    input  logic                   we_b,
    input  logic [AW-1:0]          wa_b,
    input  logic [WIDTH-1:0]       wd_b,
    input  logic [NRP*AW-1:0]      ra,
    output logic [NRP*WIDTH-1:0]   rd,
    output logic [NRP-1:0]         rbusy,
    input  logic                   claim_en,
    input  logic [AW-1:0]          claim_addr,
    output logic                   claim_ok,
    output logic [NREGS-1:0]       busy_vec,
    output logic                   waw_err
);

    logic [WIDTH-1:0] mem_q [NREGS];
    logic [WIDTH-1:0] mem_d [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic             waw_q, waw_d;

    // An address is usable when it maps to a real, writable register.
    function automatic logic addr_valid(input logic [AW-1:0] a);
        return (32'(a) < NREGS) && !(ZERO_R0 && (a == '0));
    endfunction

    // A same-cycle port-B return frees the register, so it may be re-claimed at once.
    assign claim_ok = claim_en && addr_valid(claim_addr) &&
                      (!busy_q[claim_addr] || (we_b && (wa_b == claim_addr)));

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic             hit_a, hit_b;
        logic [WIDTH-1:0] data;
        logic             pend;

        assign addr = ra[i*AW +: AW];

        always_comb begin
            hit_b = BYPASS && we_b && (wa_b == addr);
            hit_a = BYPASS && we_a && (wa_a == addr);
            data  = '0;
            pend  = 1'b0;
            if (addr_valid(addr)) begin
                if (hit_b) begin
                    data = wd_b;
                end else if (hit_a) begin
                    data = wd_a;
                end else begin
                    data = mem_q[addr];
                end
                pend = busy_q[addr] && !hit_b;
            end
        end

        assign rd[i*WIDTH +: WIDTH] = data;
        assign rbusy[i]             = pend;
    end

    always_comb begin
        mem_d  = mem_q;
        busy_d = busy_q;
        waw_d  = 1'b0;
        if (we_a && addr_valid(wa_a)) begin
            mem_d[wa_a] = wd_a;
            waw_d       = busy_q[wa_a];
        end
        // Port B is applied last so it wins an address collision with port A.
        if (we_b && addr_valid(wa_b)) begin
            mem_d[wa_b]  = wd_b;
            busy_d[wa_b] = 1'b0;
        end
        if (claim_ok) begin
            busy_d[claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge ph1) begin
        if (reset) begin
            mem_q  <= '{default: '0};
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    assign busy_vec = busy_q;
    assign waw_err  = waw_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed vector table, a hand-written ZERO_R0 sequence and a
// randomized run against an array-based reference model.
module tb_regfile_sb;

    typedef struct packed {
        logic            reset;
        logic            we_a;
        logic [2:0]      wa_a;
        logic [7:0]      wd_a;
        logic            we_b;
        logic [2:0]      wa_b;
        logic [7:0]      wd_b;
        logic [3:0][2:0] ra;
        logic            claim_en;
        logic [2:0]      claim_addr;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       chk;
        logic [7:0] rd0;
        logic [7:0] rd1;
        logic [1:0] rb;
        logic       cok;
        logic [7:0] busy;
        logic       waw;
        logic [7:0] nb;
    } vec_t;

    logic  ph1;
    stim_t sx, sz;
    int    checks, failures;

    logic [5:0]  x_ra;
    logic [15:0] x_rd, n_rd;
    logic [1:0]  x_rbusy, n_rbusy;
    logic        x_cok, n_cok, x_waw, n_waw, z_cok, z_waw;
    logic [7:0]  x_busy, n_busy;
    logic [31:0] z_rd;
    logic [3:0]  z_rbusy;
    logic [5:0]  z_busy;

    assign x_ra = {sx.ra[1], sx.ra[0]};

    regfile_sb #(.WIDTH(8), .NREGS(8), .NRP(2), .ZERO_R0(1'b0), .BYPASS(1'b1)) u_dut_x (
        .ph1(ph1), .reset(sx.reset),
        .we_a(sx.we_a), .wa_a(sx.wa_a), .wd_a(sx.wd_a),
        .we_b(sx.we_b), .wa_b(sx.wa_b), .wd_b(sx.wd_b),
        .ra(x_ra), .rd(x_rd), .rbusy(x_rbusy),
        .claim_en(sx.claim_en), .claim_addr(sx.claim_addr), .claim_ok(x_cok),
        .busy_vec(x_busy), .waw_err(x_waw)
    );

    regfile_sb #(.WIDTH(8), .NREGS(8), .NRP(2), .ZERO_R0(1'b0), .BYPASS(1'b0)) u_dut_n (
        .ph1(ph1), .reset(sx.reset),
        .we_a(sx.we_a), .wa_a(sx.wa_a), .wd_a(sx.wd_a),
        .we_b(sx.we_b), .wa_b(sx.wa_b), .wd_b(sx.wd_b),
        .ra(x_ra), .rd(n_rd), .rbusy(n_rbusy),
        .claim_en(sx.claim_en), .claim_addr(sx.claim_addr), .claim_ok(n_cok),
        .busy_vec(n_busy), .waw_err(n_waw)
    );

    regfile_sb #(.WIDTH(8), .NREGS(6), .NRP(4), .ZERO_R0(1'b1), .BYPASS(1'b1)) u_dut_z (
        .ph1(ph1), .reset(sz.reset),
        .we_a(sz.we_a), .wa_a(sz.wa_a), .wd_a(sz.wd_a),
        .we_b(sz.we_b), .wa_b(sz.wa_b), .wd_b(sz.wd_b),
        .ra(sz.ra), .rd(z_rd), .rbusy(z_rbusy),
        .claim_en(sz.claim_en), .claim_addr(sz.claim_addr), .claim_ok(z_cok),
        .busy_vec(z_busy), .waw_err(z_waw)
    );

    initial ph1 = 1'b0;
    always #5 ph1 = ~ph1;

    // Reference model: config 0 = 8 regs (shared by both x duts), config 1 = 6 regs, r0 zero.
    int         nregs_c [2] = '{8, 6};
    bit         zero_c  [2] = '{1'b0, 1'b1};
    logic [7:0] m_mem   [2][8];
    bit         m_busy  [2][8];
    bit         m_waw   [2];

    function automatic bit m_valid(int c, logic [2:0] a);
        return (int'(a) < nregs_c[c]) && !(zero_c[c] && (a == 3'd0));
    endfunction

    function automatic logic [7:0] m_rd(int c, stim_t s, int i, bit byp);
        logic [2:0] a = s.ra[i];
        if (!m_valid(c, a)) return 8'h00;
        if (byp && s.we_b && (s.wa_b == a)) return s.wd_b;
        if (byp && s.we_a && (s.wa_a == a)) return s.wd_a;
        return m_mem[c][a];
    endfunction

    function automatic logic m_rb(int c, stim_t s, int i, bit byp);
        logic [2:0] a = s.ra[i];
        return m_valid(c, a) && m_busy[c][a] && !(byp && s.we_b && (s.wa_b == a));
    endfunction

    function automatic logic m_cok(int c, stim_t s);
        return s.claim_en && m_valid(c, s.claim_addr) &&
               (!m_busy[c][s.claim_addr] || (s.we_b && (s.wa_b == s.claim_addr)));
    endfunction

    function automatic logic [7:0] m_bvec(int c);
        logic [7:0] v = 8'h00;
        for (int k = 0; k < nregs_c[c]; k++) v[k] = m_busy[c][k];
        return v;
    endfunction

    task automatic m_step(int c, stim_t s);
        bit ok;
        ok = m_cok(c, s);
        if (s.reset) begin
            for (int k = 0; k < 8; k++) begin
                m_mem[c][k]  = 8'h00;
                m_busy[c][k] = 1'b0;
            end
            m_waw[c] = 1'b0;
        end else begin
            m_waw[c] = s.we_a && m_valid(c, s.wa_a) && m_busy[c][s.wa_a];
            if (s.we_a && m_valid(c, s.wa_a)) m_mem[c][s.wa_a] = s.wd_a;
            if (s.we_b && m_valid(c, s.wa_b)) begin
                m_mem[c][s.wa_b]  = s.wd_b;
                m_busy[c][s.wa_b] = 1'b0;
            end
            if (ok) m_busy[c][s.claim_addr] = 1'b1;
        end
    endtask

    task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(stim_t x, stim_t z);
        @(posedge ph1);
        #1;
        sx = x;
        sz = z;
        @(negedge ph1);
    endtask

    function automatic stim_t mk(logic rst, logic wea, logic [2:0] waa, logic [7:0] wda,
                                 logic web, logic [2:0] wab, logic [7:0] wdb,
                                 logic [2:0] r0, logic [2:0] r1, logic ce, logic [2:0] ca);
        stim_t s = '0;
        s.reset = rst; s.we_a = wea; s.wa_a = waa; s.wd_a = wda;
        s.we_b = web; s.wa_b = wab; s.wd_b = wdb;
        s.ra[0] = r0; s.ra[1] = r1; s.claim_en = ce; s.claim_addr = ca;
        return s;
    endfunction

    function automatic vec_t v(stim_t s, logic chk, logic [7:0] e0, logic [7:0] e1,
                               logic [1:0] erb, logic ecok, logic [7:0] ebusy, logic ewaw,
                               logic [7:0] enb);
        vec_t r;
        r.s = s; r.chk = chk; r.rd0 = e0; r.rd1 = e1; r.rb = erb; r.cok = ecok;
        r.busy = ebusy; r.waw = ewaw; r.nb = enb;
        return r;
    endfunction

    function automatic stim_t rnd_stim();
        stim_t s;
        s.reset      = ($urandom_range(0, 59) == 0);
        s.we_a       = 1'($urandom_range(0, 1));
        s.wa_a       = 3'($urandom_range(0, 7));
        s.wd_a       = 8'($urandom);
        s.we_b       = 1'($urandom_range(0, 1));
        s.wa_b       = 3'($urandom_range(0, 7));
        s.wd_b       = 8'($urandom);
        for (int k = 0; k < 4; k++) s.ra[k] = 3'($urandom_range(0, 7));
        s.claim_en   = ($urandom_range(0, 2) != 0);
        s.claim_addr = 3'($urandom_range(0, 7));
        return s;
    endfunction

    vec_t  tbl [$];
    stim_t z0, zs;

    initial begin
        checks   = 0;
        failures = 0;
        sx       = '0;
        sz       = '0;
        z0       = '0;

        tbl.push_back(v(mk(1'b1, 1'b1, 3'd3, 8'hAA, 1'b1, 3'd4, 8'hBB, 3'd0, 3'd0, 1'b1, 3'd1),
                        1'b0, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h5A, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd3, 3'd2, 1'b0, 3'd0),
                        1'b1, 8'h5A, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h5A));
        tbl.push_back(v(mk(1'b0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd2, 8'h22, 3'd2, 3'd3, 1'b0, 3'd0),
                        1'b1, 8'h22, 8'h5A, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd2, 3'd7, 1'b0, 3'd0),
                        1'b1, 8'h22, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h22));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b1, 3'd4),
                        1'b1, 8'h00, 8'h00, 2'b00, 1'b1, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b1, 3'd4),
                        1'b1, 8'h5A, 8'h00, 2'b10, 1'b0, 8'h10, 1'b0, 8'h5A));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h3C, 3'd3, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h5A, 8'h3C, 2'b00, 1'b0, 8'h10, 1'b0, 8'h5A));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd4, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h3C, 8'h3C, 2'b00, 1'b0, 8'h00, 1'b0, 8'h3C));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 1'b1, 3'd5),
                        1'b1, 8'h00, 8'h3C, 2'b00, 1'b1, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 1'b1, 3'd4),
                        1'b1, 8'h00, 8'h3C, 2'b01, 1'b1, 8'h20, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b1, 3'd5, 8'h07, 1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h07, 8'h3C, 2'b11, 1'b0, 8'h30, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd5, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h07, 8'h3C, 2'b11, 1'b0, 8'h30, 1'b1, 8'h07));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd4, 8'h44, 3'd5, 3'd4, 1'b1, 3'd4),
                        1'b1, 8'h07, 8'h44, 2'b01, 1'b1, 8'h30, 1'b0, 8'h07));
        tbl.push_back(v(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 8'h99, 3'd5, 3'd4, 1'b0, 3'd0),
                        1'b1, 8'h07, 8'h44, 2'b11, 1'b0, 8'h30, 1'b0, 8'h07));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd6, 3'd5, 1'b0, 3'd0),
                        1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00));
        tbl.push_back(v(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 3'd4, 3'd3, 1'b0, 3'd0),
                        1'b1, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 1'b0, 8'h00));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].s, z0);
            if (tbl[i].chk) begin
                check("tbl_rd0", i, 32'(x_rd[7:0]), 32'(tbl[i].rd0));
                check("tbl_rd1", i, 32'(x_rd[15:8]), 32'(tbl[i].rd1));
                check("tbl_rbusy", i, 32'(x_rbusy), 32'(tbl[i].rb));
                check("tbl_claim_ok", i, 32'(x_cok), 32'(tbl[i].cok));
                check("tbl_busy_vec", i, 32'(x_busy), 32'(tbl[i].busy));
                check("tbl_waw_err", i, 32'(x_waw), 32'(tbl[i].waw));
                check("tbl_rd0_nobypass", i, 32'(n_rd[7:0]), 32'(tbl[i].nb));
            end
        end

        // ZERO_R0 with 6 registers and four read ports.
        zs = '0;
        zs.reset = 1'b1; zs.we_a = 1'b1; zs.wd_a = 8'hEE;
        drive('0, zs);

        zs = '0;
        zs.we_a = 1'b1; zs.wa_a = 3'd0; zs.wd_a = 8'hFF;
        zs.we_b = 1'b1; zs.wa_b = 3'd7; zs.wd_b = 8'hFF;
        zs.ra[0] = 3'd0; zs.ra[1] = 3'd7; zs.ra[2] = 3'd1; zs.ra[3] = 3'd2;
        zs.claim_en = 1'b1; zs.claim_addr = 3'd0;
        drive('0, zs);
        check("z_rd_dropped", 0, z_rd, 32'h0);
        check("z_claim_r0", 0, 32'(z_cok), 32'h0);
        check("z_busy_vec", 0, 32'(z_busy), 32'h0);

        zs = '0;
        zs.we_a = 1'b1; zs.wa_a = 3'd1; zs.wd_a = 8'h11;
        zs.we_b = 1'b1; zs.wa_b = 3'd5; zs.wd_b = 8'h55;
        zs.ra[0] = 3'd1; zs.ra[1] = 3'd5; zs.ra[2] = 3'd0; zs.ra[3] = 3'd7;
        drive('0, zs);
        check("z_rd_bypass", 1, z_rd, 32'h0000_5511);
        check("z_busy_vec", 1, 32'(z_busy), 32'h0);

        zs = '0;
        zs.ra[0] = 3'd5; zs.ra[1] = 3'd1; zs.ra[2] = 3'd3; zs.ra[3] = 3'd0;
        zs.claim_en = 1'b1; zs.claim_addr = 3'd5;
        drive('0, zs);
        check("z_rd_stored", 2, z_rd, 32'h0000_1155);
        check("z_claim_ok", 2, 32'(z_cok), 32'h1);
        check("z_rbusy", 2, 32'(z_rbusy), 32'h0);

        zs = '0;
        zs.ra[0] = 3'd5; zs.ra[1] = 3'd1; zs.ra[2] = 3'd4; zs.ra[3] = 3'd2;
        zs.claim_en = 1'b1; zs.claim_addr = 3'd5;
        drive('0, zs);
        check("z_busy_vec", 3, 32'(z_busy), 32'h20);
        check("z_rbusy", 3, 32'(z_rbusy), 32'h1);
        check("z_reclaim", 3, 32'(z_cok), 32'h0);
        check("z_rd_four", 3, z_rd, 32'h0000_1155);

        // Randomized run against the model.
        zs = '0;
        zs.reset = 1'b1;
        drive(zs, zs);
        m_step(0, zs);
        m_step(1, zs);
        for (int n = 0; n < 600; n++) begin
            drive(rnd_stim(), rnd_stim());
            check("rnd_x_rd", n, 32'(x_rd), 32'({m_rd(0, sx, 1, 1'b1), m_rd(0, sx, 0, 1'b1)}));
            check("rnd_n_rd", n, 32'(n_rd), 32'({m_rd(0, sx, 1, 1'b0), m_rd(0, sx, 0, 1'b0)}));
            check("rnd_x_rbusy", n, 32'(x_rbusy),
                  32'({m_rb(0, sx, 1, 1'b1), m_rb(0, sx, 0, 1'b1)}));
            check("rnd_n_rbusy", n, 32'(n_rbusy),
                  32'({m_rb(0, sx, 1, 1'b0), m_rb(0, sx, 0, 1'b0)}));
            check("rnd_x_cok", n, 32'(x_cok), 32'(m_cok(0, sx)));
            check("rnd_n_cok", n, 32'(n_cok), 32'(m_cok(0, sx)));
            check("rnd_x_busy", n, 32'(x_busy), 32'(m_bvec(0)));
            check("rnd_n_busy", n, 32'(n_busy), 32'(m_bvec(0)));
            check("rnd_x_waw", n, 32'(x_waw), 32'(m_waw[0]));
            check("rnd_n_waw", n, 32'(n_waw), 32'(m_waw[0]));
            check("rnd_z_rd", n, z_rd, {m_rd(1, sz, 3, 1'b1), m_rd(1, sz, 2, 1'b1),
                                        m_rd(1, sz, 1, 1'b1), m_rd(1, sz, 0, 1'b1)});
            check("rnd_z_rbusy", n, 32'(z_rbusy),
                  32'({m_rb(1, sz, 3, 1'b1), m_rb(1, sz, 2, 1'b1),
                       m_rb(1, sz, 1, 1'b1), m_rb(1, sz, 0, 1'b1)}));
            check("rnd_z_cok", n, 32'(z_cok), 32'(m_cok(1, sz)));
            check("rnd_z_busy", n, 32'(z_busy), 32'(m_bvec(1)));
            check("rnd_z_waw", n, 32'(z_waw), 32'(m_waw[1]));
            m_step(0, sx);
            m_step(1, sz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file with a per-register pending (scoreboard) bit.
- Successor to the fixed 8x8, 2-read/1-write, no-reset register file used by the current datapath.
- Adds configurable width/depth/read-port count, a second write port for load return, optional hardwired zero register, write-through bypass, synchronous reset of contents, and busy tracking so the controller can issue multi-cycle loads and stall on RAW/WAW hazards.

Parameters:
- WIDTH, 8, data width in bits.
- NREGS, 8, number of registers (2..32; need not be a power of two).
- AW, $clog2(NREGS), address width.
- NRP, 2, number of combinational read ports (1..4).
- ZERO_R0, 0, 1 = register 0 reads as 0, ignores writes, and is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports.

Ports:
- ph1, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- we_a, input, 1, write enable, port A (ALU result).
- wa_a, input, AW, write address, port A.
- wd_a, input, WIDTH, write data, port A.
- we_b, input, 1, write enable, port B (load return); clears busy.
- wa_b, input, AW, write address, port B.
- wd_b, input, WIDTH, write data, port B.
- ra, input, NRP*AW, packed read addresses; port i = ra[i*AW +: AW].
- rd, output, NRP*WIDTH, packed read data.
- rbusy, output, NRP, per-port: the addressed register is pending.
- claim_en, input, 1, request to mark claim_addr pending (load issued).
- claim_addr, input, AW, register to claim.
- claim_ok, output, 1, combinational: the claim is accepted this cycle.
- busy_vec, output, NREGS, registered busy bits.
- waw_err, output, 1, registered one-cycle pulse: port A wrote a busy register.

Behaviour:
- Reset (rising ph1 with reset=1): all registers <= 0, busy_vec <= 0, waw_err <= 0. Reset overrides every write and claim in that cycle.
- Reads are combinational. Port i returns reg[ra_i].
  - Address >= NREGS returns 0.
  - ZERO_R0=1 and address 0 returns 0.
- Bypass (BYPASS=1):
  - If we_b and wa_b==ra_i (and the address is valid and writable), rd_i = wd_b.
  - Else if we_a and wa_a==ra_i, rd_i = wd_a.
  - Else rd_i = stored value.
  - BYPASS=0: rd_i is always the stored (pre-edge) value.
- Writes at the rising edge:
  - Port A writes wa_a <= wd_a; port B writes wa_b <= wd_b.
  - Same address on both ports: port B wins.
  - Writes to address >= NREGS, or to address 0 when ZERO_R0=1, are dropped.
- Scoreboard:
  - claim_ok = claim_en & valid(claim_addr) & (~busy[claim_addr] | (we_b & wa_b==claim_addr)).
  - valid() excludes addresses >= NREGS, and address 0 when ZERO_R0=1.
  - On claim_ok: busy[claim_addr] <= 1. Same-cycle port-B return plus re-claim leaves the bit set and the data written.
  - A rejected claim leaves state unchanged; the controller must retry.
  - we_b to a register with busy=1 and no same-address claim: busy <= 0.
  - we_b to a non-busy register: data is written, busy is unchanged.
  - we_a to a busy register: data is written, busy is unchanged, waw_err = 1 next cycle only.
- rbusy_i = busy[ra_i] & ~(BYPASS & we_b & wa_b==ra_i). Invalid addresses give 0.
- No internal latency beyond one edge: data written at edge k is readable from the array in cycle k+1. With BYPASS=1 it is also visible in cycle k.
- busy_vec bit 0 is constant 0 when ZERO_R0=1. Bits for unused addresses do not exist (vector width is NREGS).

Test Plan:
- Reset then read: reset=1 for 1 cycle, write attempts present → all rd=0, busy_vec=0, waw_err=0. Then we_a, wa_a=3, wd_a=8'h5A; next cycle ra0=3 → rd0=8'h5A.
- Dual-write collision: we_a=we_b=1, wa_a=wa_b=2, wd_a=8'h11, wd_b=8'h22 → same-cycle rd (ra0=2, BYPASS=1) = 8'h22, stored value = 8'h22. With BYPASS=0, same-cycle rd0 = old value 0.
- ZERO_R0=1, NREGS=6: write 8'hFF to addr 0 and addr 7 → reads of 0 and 7 return 0. claim_en on addr 0 → claim_ok=0, busy_vec unchanged.
- Load flow: claim addr 4 → claim_ok=1, busy_vec=6'b010000 next cycle. Ra1=4 → rbusy1=1. Second claim on 4 → claim_ok=0. we_b wa_b=4 wd_b=8'h3C → same cycle rbusy1=0, rd1=8'h3C, next cycle busy bit 4=0.
- WAW: addr 5 busy, we_a wa_a=5 wd_a=8'h07 → waw_err=1 for exactly one cycle, reg5=8'h07, busy[5] still 1.
- Reset mid-operation: busy_vec=8'b00110000 and we_b pending, reset=1 → next cycle busy_vec=0, all registers 0, write dropped. NRP=4 variant repeated with four distinct ra.
